// File: rtl/fifo_sc_hs.sv
// fifo_sc_hs: single-clock valid/ready FIFO with any depth >= 2.
// SHOW_AHEAD="ON" presents the head word straight from memory; "OFF" adds
// a registered output stage that counts as one of the DEPTH words.
// Optional macro FIFO_SC_HS_ALMOST_EN enables registered almost_full_o /
// almost_empty_o; without it both outputs are tied low.

package fifo_sc_hs_pkg;
   // Ceiling log2, used for pointer and count widths.
   function automatic int clogb2_f(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

module fifo_sc_hs
   import fifo_sc_hs_pkg::*;
#(
   parameter int          DW         = 32,
   parameter int          DEPTH      = 32,
   parameter logic [23:0] SHOW_AHEAD = 24'("ON"),
   parameter int          AF_LEVEL   = DEPTH - 2,
   parameter int          AE_LEVEL   = 2,
   localparam int         CW         = clogb2_f(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          srst_i,
   input  logic          s_valid_i,
   input  logic [DW-1:0] s_data_i,
   output logic          s_ready_o,
   output logic          m_valid_o,
   output logic [DW-1:0] m_data_o,
   input  logic          m_ready_i,
   input  logic          clr_err_i,
   output logic          full_o,
   output logic          empty_o,
   output logic          almost_full_o,
   output logic          almost_empty_o,
   output logic          overflow_o,
   output logic [CW-1:0] count_o
);

   localparam int PW     = clogb2_f(DEPTH);
   localparam bit SA_OFF = (SHOW_AHEAD == 24'("OFF"));

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q, count_nxt;
   logic          full_q, empty_q, ovf_q;
   logic          wr, rd, mem_rd;

   // Pointers wrap explicitly so non power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign s_ready_o  = !full_q;
   assign wr         = s_valid_i && !full_q;
   assign rd         = m_valid_o && m_ready_i;
   assign count_o    = count_q;
   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign overflow_o = ovf_q;

   // Next occupancy: +1 write only, -1 read only, else unchanged.
   always_comb begin
      count_nxt = count_q;
      if (wr && !rd)      count_nxt = count_q + 1'b1;
      else if (rd && !wr) count_nxt = count_q - 1'b1;
   end

   // Storage write port; contents survive reset, reset only blocks the write.
   always_ff @(posedge clk_i) begin
      if (wr && !srst_i) mem[wptr_q] <= s_data_i;
   end

   // Pointers, occupancy and registered full/empty flags.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (wr)     wptr_q <= ptr_inc(wptr_q);
         if (mem_rd) rptr_q <= ptr_inc(rptr_q);
         count_q <= count_nxt;
         full_q  <= (count_nxt == CW'(DEPTH));
         empty_q <= (count_nxt == '0);
      end
   end

   // Sticky overflow; a new overflow beats a concurrent clear.
   always_ff @(posedge clk_i) begin
      if (srst_i)                      ovf_q <= 1'b0;
      else if (s_valid_i && full_q)    ovf_q <= 1'b1;
      else if (clr_err_i)              ovf_q <= 1'b0;
   end

   generate
      if (SA_OFF) begin : g_reg_out
         logic [CW-1:0] mem_cnt_q;
         logic [DW-1:0] out_q;
         logic          out_vld_q;
         logic          load;

         // Refill the output register when it is vacant or being consumed.
         assign load      = (!out_vld_q || rd) && (mem_cnt_q != '0);
         assign mem_rd    = load;
         assign m_valid_o = out_vld_q;
         assign m_data_o  = out_q;

         // Memory-only occupancy plus the head-word output register.
         always_ff @(posedge clk_i) begin
            if (srst_i) begin
               mem_cnt_q <= '0;
               out_q     <= '0;
               out_vld_q <= 1'b0;
            end else begin
               case ({wr, load})
                  2'b10:   mem_cnt_q <= mem_cnt_q + 1'b1;
                  2'b01:   mem_cnt_q <= mem_cnt_q - 1'b1;
                  default: ;
               endcase
               if (load) begin
                  out_q     <= mem[rptr_q];
                  out_vld_q <= 1'b1;
               end else if (rd) begin
                  out_vld_q <= 1'b0;
               end
            end
         end
      end else begin : g_show_ahead
         // Read-through: head word is visible the cycle after it is written.
         assign mem_rd    = rd;
         assign m_valid_o = !empty_q;
         assign m_data_o  = empty_q ? '0 : mem[rptr_q];
      end
   endgenerate

`ifdef FIFO_SC_HS_ALMOST_EN
   logic af_q, ae_q;

   // Threshold flags track the same next-count as count_o.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         af_q <= 1'b0;
         ae_q <= 1'b1;
      end else begin
         af_q <= (int'(count_nxt) >= AF_LEVEL);
         ae_q <= (int'(count_nxt) <= AE_LEVEL);
      end
   end

   assign almost_full_o  = af_q;
   assign almost_empty_o = ae_q;
`else
   assign almost_full_o  = 1'b0;
   assign almost_empty_o = 1'b0;
`endif

endmodule

// File: doc/fifo_sc_hs.md
FIFO_SC_HS -- requirements
Module: fifo_sc_hs

Interface
REQ-001 The block SHALL have parameter DW, default 32, data width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 32, storage depth in words (any integer >=2, not restricted to powers of two).
REQ-003 The block SHALL have parameter SHOW_AHEAD, default "ON", output mode ("ON" = memory read-through, "OFF" = registered output stage).
REQ-004 The block SHALL have parameter AF_LEVEL, default DEPTH-2, almost-full threshold.
REQ-005 The block SHALL have parameter AE_LEVEL, default 2, almost-empty threshold.
REQ-006 The block SHALL have these ports, with CW = clogb2_f(DEPTH+1):
- clk_i  in  1  single clock; all logic on its rising edge.
- srst_i  in  1  reset, synchronous, active-high.
- s_valid_i  in  1  write request.
- s_data_i  in  DW  write data.
- s_ready_o  out  1  write can be accepted.
- m_valid_o  out  1  read data available.
- m_data_o  out  DW  read data.
- m_ready_i  in  1  consumer accepts m_data_o.
- clr_err_i  in  1  clears overflow_o.
- full_o  out  1  no free word.
- empty_o  out  1  no stored word.
- almost_full_o  out  1  count_o >= AF_LEVEL.
- almost_empty_o  out  1  count_o <= AE_LEVEL.
- overflow_o  out  1  sticky: write attempted while not ready.
- count_o  out  CW  words held.

Function
REQ-007 A write SHALL occur when s_valid_i && s_ready_o; a read SHALL occur when m_valid_o && m_ready_i.
REQ-008 s_ready_o SHALL equal !full_o; with s_valid_i && !s_ready_o, data SHALL be dropped and no state other than overflow_o SHALL change.
REQ-009 Read and write pointers SHALL range 0..DEPTH-1 and wrap from DEPTH-1 to 0 explicitly, with no power-of-two modulo.
REQ-010 count_o, full_o and empty_o SHALL be registered; count_o SHALL be +1 on write only, -1 on read only, and unchanged on both or neither.
REQ-011 full_o SHALL be 1 exactly when count_o == DEPTH; empty_o SHALL be 1 exactly when count_o == 0.
REQ-012 With SHOW_AHEAD="ON": m_valid_o = !empty_o; m_data_o = word at read pointer, combinational from memory; a write at edge N into an empty block SHALL give m_valid_o=1 in the cycle after edge N.
REQ-013 With SHOW_AHEAD="OFF":
- one output register holds the head word; m_data_o and m_valid_o are flops.
- the register loads when empty of valid data or read this cycle, and memory is non-empty.
- first-word latency is 2 edges (write at edge N, m_valid_o=1 after edge N+1).
- count_o includes the word in the output register.
REQ-014 While m_valid_o && !m_ready_i, m_data_o and m_valid_o SHALL hold stable.
REQ-015 When full, a simultaneous read SHALL be accepted and the write refused (s_ready_o already low); full_o SHALL clear after that edge.
REQ-016 When empty, a simultaneous m_ready_i SHALL have no effect.
REQ-017 overflow_o SHALL set on the edge after s_valid_i && !s_ready_o and hold until clr_err_i; if both occur in one cycle, set SHALL win.

Reset
REQ-018 On srst_i at a rising edge, the block SHALL set: pointers 0, count_o=0, empty_o=1, full_o=0, s_ready_o=1, m_valid_o=0, m_data_o=0, overflow_o=0, almost_empty_o=1 (when enabled), almost_full_o=0.
REQ-019 srst_i SHALL override any concurrent write or read; memory contents need not be cleared.
REQ-020 Reset mid-operation SHALL discard all stored words, including the output register.

Configuration
REQ-021 Macro FIFO_SC_HS_ALMOST_EN:
- defined: almost_full_o and almost_empty_o are registered, updated in the same cycle as count_o, per REQ-006.
- undefined: both are tied to 0, the threshold logic is absent, and AF_LEVEL/AE_LEVEL are ignored.

Verification
REQ-022 The bench SHALL cover these scenarios:
- DEPTH=5, ON: write 0x11..0x55 -> full_o=1, count_o=5, s_ready_o=0; 6th write 0x66 -> overflow_o=1, data dropped, reads return 0x11..0x55 in order.
- DEPTH=5: 12 write/read pairs, continuous streaming -> pointers wrap 4->0 twice, data in order, count_o stays 0/1.
- DEPTH=5, full, read+write same cycle -> read accepted, write refused, count_o=4, full_o=0.
- OFF: single write 0xA5 at edge N -> m_valid_o=1 and m_data_o=0xA5 after edge N+1; m_ready_i=0 for 3 cycles -> output held.
- ALMOST_EN, AF_LEVEL=4, AE_LEVEL=1 -> almost_full_o rises at count 4, almost_empty_o falls at count 2; with macro undefined both stay 0.
- srst_i with count_o=3 and overflow_o=1 -> all outputs at reset values; clr_err_i concurrent with new overflow -> overflow_o stays 1.
